// File: rtl/proc_control_unit_pkg.sv
// Shared constants for the processor control unit: opcodes, bus selects,
// ALU codes and the sequencer state type.
package proc_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    localparam logic [3:0] SEL_R0  = 4'd0;
    localparam logic [3:0] SEL_R1  = 4'd1;
    localparam logic [3:0] SEL_R2  = 4'd2;
    localparam logic [3:0] SEL_R3  = 4'd3;
    localparam logic [3:0] SEL_R4  = 4'd4;
    localparam logic [3:0] SEL_R5  = 4'd5;
    localparam logic [3:0] SEL_R6  = 4'd6;
    localparam logic [3:0] SEL_R7  = 4'd7;
    localparam logic [3:0] SEL_IMM = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_IDLE = 3'b100;

    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational output decode: maps sequencer state + instruction register
// to datapath controls; hold masks every side-effecting enable.
module proc_ctrl_decode
    import proc_control_unit_pkg::*;
(
    input  state_t      i_state,
    input  logic [8:0]  i_ir,
    input  logic        i_hold,
    output logic [3:0]  o_mux_sel,
    output logic [7:0]  o_r_en,
    output logic        o_a_in,
    output logic        o_g_in,
    output logic [2:0]  o_alu_op,
    output logic        o_done,
    output logic        o_err,
    output logic        o_din_ready
);

    logic [2:0] w_op;
    logic [2:0] w_rx;
    logic [2:0] w_ry;

    assign w_op = i_ir[8:6];
    assign w_rx = i_ir[5:3];
    assign w_ry = i_ir[2:0];

    always_comb begin
        o_mux_sel   = SEL_R0;
        o_r_en      = 8'd0;
        o_a_in      = 1'b0;
        o_g_in      = 1'b0;
        o_alu_op    = ALU_IDLE;
        o_done      = 1'b0;
        o_err       = 1'b0;
        o_din_ready = 1'b0;
        case (i_state)
            ST_FETCH: o_din_ready = 1'b1;
            ST_LOAD_A: begin
                if (w_op == OP_MOVI) begin
                    o_mux_sel = SEL_IMM;
                    o_r_en    = reg_onehot(w_rx);
                    o_done    = 1'b1;
                end else if (is_alu_op(w_op)) begin
                    o_mux_sel = {1'b0, w_rx};
                    o_a_in    = 1'b1;
                end else begin
                    o_err = 1'b1;
                end
            end
            ST_EXEC: begin
                o_g_in    = 1'b1;
                o_mux_sel = (w_op == OP_ADDI) ? SEL_IMM : {1'b0, w_ry};
                o_alu_op  = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            ST_WRITE: begin
                o_mux_sel = SEL_G;
                o_r_en    = reg_onehot(w_rx);
                o_done    = 1'b1;
            end
            default: ;
        endcase
        // Bus select and ALU code may still show the frozen step; nothing latches them.
        if (i_hold) begin
            o_r_en      = 8'd0;
            o_a_in      = 1'b0;
            o_g_in      = 1'b0;
            o_done      = 1'b0;
            o_err       = 1'b0;
            o_din_ready = 1'b0;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle processor controller: fetches 9-bit instructions and sequences
// movi / add / addi / sub through LOAD_A, EXEC and WRITE.
module proc_control_unit
    import proc_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        hold,
    output logic [8:0]  ir,
    output logic [3:0]  mux_sel,
    output logic [7:0]  r_en,
    output logic        a_in,
    output logic        g_in,
    output logic [2:0]  alu_op,
    output logic        done,
    output logic        err,
    output logic [15:0] retired
);

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_ir;
    logic [15:0] r_retired;
    logic        w_accept;

    assign w_accept = (r_state == ST_FETCH) && din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!hold) begin
            case (r_state)
                ST_FETCH:  if (w_accept) w_next = ST_LOAD_A;
                ST_LOAD_A: w_next = is_alu_op(r_ir[8:6]) ? ST_EXEC : ST_FETCH;
                ST_EXEC:   w_next = ST_WRITE;
                ST_WRITE:  w_next = ST_FETCH;
                default:   w_next = ST_FETCH;
            endcase
        end
    end

    proc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_ir        (r_ir),
        .i_hold      (hold),
        .o_mux_sel   (mux_sel),
        .o_r_en      (r_en),
        .o_a_in      (a_in),
        .o_g_in      (g_in),
        .o_alu_op    (alu_op),
        .o_done      (done),
        .o_err       (err),
        .o_din_ready (din_ready)
    );

    // done is already masked by hold, so the counter freezes with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir      <= 9'd0;
            r_retired <= 16'd0;
        end else begin
            if (w_accept) r_ir <= din;
            if (done)     r_retired <= r_retired + 16'd1;
        end
    end

    assign ir      = r_ir;
    assign retired = r_retired;

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench: per-instruction expected step tables built from the
// instruction-level rules, random holds and garbage inputs, plus directed cases.
module tb_proc_control_unit;

    logic        clk = 1'b0;
    logic        rst, din_valid, hold;
    logic [8:0]  din;
    logic        din_ready, a_in, g_in, done, err;
    logic [8:0]  ir;
    logic [3:0]  mux_sel;
    logic [7:0]  r_en;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    proc_control_unit dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .hold(hold), .ir(ir), .mux_sel(mux_sel), .r_en(r_en), .a_in(a_in), .g_in(g_in),
        .alu_op(alu_op), .done(done), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [15:0] m_ret;
    logic [8:0]  m_ir;

    typedef struct packed {
        logic [3:0] ms;
        logic [7:0] re;
        logic       a, g;
        logic [2:0] alu;
        logic       d, e;
    } step_t;
    step_t plan[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle-by-cycle behaviour after accept, from the instruction rules.
    function automatic void build(input logic [8:0] w);
        logic [2:0] op, rx, ry;
        logic [7:0] oh;
        op = w[8:6]; rx = w[5:3]; ry = w[2:0];
        oh = 8'd0;
        oh[rx] = 1'b1;
        plan.delete();
        if (op == 3'd0)
            plan.push_back('{4'd8, oh, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
        else if (op <= 3'd3) begin
            plan.push_back('{{1'b0, rx}, 8'd0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0});
            plan.push_back('{(op == 3'd2) ? 4'd8 : {1'b0, ry}, 8'd0, 1'b0, 1'b1,
                             (op == 3'd3) ? 3'b010 : 3'b001, 1'b0, 1'b0});
            plan.push_back('{4'd9, oh, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
        end else
            plan.push_back('{4'd0, 8'd0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1});
    endfunction

    task automatic check_step(input string tg, input step_t s);
        chk({tg, "_mux"},  mux_sel,   s.ms);
        chk({tg, "_ren"},  r_en,      s.re);
        chk({tg, "_ain"},  a_in,      s.a);
        chk({tg, "_gin"},  g_in,      s.g);
        chk({tg, "_alu"},  alu_op,    s.alu);
        chk({tg, "_done"}, done,      s.d);
        chk({tg, "_err"},  err,       s.e);
        chk({tg, "_rdy"},  din_ready, 1'b0);
    endtask

    task automatic hold_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            hold = 1'b1; din_valid = 1'($urandom); din = 9'($urandom);
            #1;
            chk("hold_ren", r_en, 8'd0);
            chk("hold_ain", a_in, 1'b0);
            chk("hold_gin", g_in, 1'b0);
            chk("hold_done", done, 1'b0);
            chk("hold_err", err, 1'b0);
            chk("hold_rdy", din_ready, 1'b0);
            chk("hold_ret", retired, m_ret);
            chk("hold_ir", ir, m_ir);
            tick();
        end
        hold = 1'b0;
    endtask

    // Called at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input string tg, input logic [8:0] w, input int hstep, input int hlen);
        if ($urandom_range(0, 3) == 0) begin
            hold = 1'b1; din_valid = 1'b1; din = ~w;
            #1;
            chk({tg, "_rdy_held"}, din_ready, 1'b0);
            tick();
            chk({tg, "_ir_noacc"}, ir, m_ir);
        end
        hold = 1'b0; din_valid = 1'b1; din = w;
        #1;
        chk({tg, "_rdy"}, din_ready, 1'b1);
        chk({tg, "_fetch_ren"}, r_en, 8'd0);
        chk({tg, "_fetch_alu"}, alu_op, 3'b100);
        tick();
        m_ir = w;
        chk({tg, "_ir"}, ir, m_ir);
        build(w);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == hstep) hold_cycles(hlen);
            else if (hstep < 0 && $urandom_range(0, 4) == 0) hold_cycles($urandom_range(1, 3));
            hold = 1'b0; din_valid = 1'($urandom); din = 9'($urandom);
            #1;
            check_step($sformatf("%s_s%0d", tg, i), plan[i]);
            tick();
            if (plan[i].d) m_ret = m_ret + 16'd1;
            chk({tg, "_ret"}, retired, m_ret);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; din_valid = 1'b0; din = 9'd0;
        m_ret = 16'd0; m_ir = 9'd0;
        #1;
        chk("rst_ren", r_en, 8'd0);
        chk("rst_mux", mux_sel, 4'd0);
        chk("rst_alu", alu_op, 3'b100);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy", din_ready, 1'b1);
        chk("rst_ret", retired, 16'd0);
        chk("rst_ir", ir, 9'd0);
        tick(); tick();
        rst = 1'b0;

        run_instr("movi", 9'b000_101_011, 9, 0);
        run_instr("add", 9'b001_010_001, 9, 0);
        run_instr("ill", 9'b110_000_000, 9, 0);
        run_instr("hold", 9'b001_110_101, 1, 3);
        run_instr("samereg", 9'b001_011_011, 9, 0);
        run_instr("addi", 9'b010_111_100, 9, 0);
        run_instr("sub", 9'b011_000_110, 9, 0);

        for (int n = 0; n < 40; n++) run_instr("rnd", 9'($urandom), -1, 0);

        // Reset during EXEC of a sub: no write may follow.
        run_instr("pre", 9'b000_000_001, 9, 0);
        hold = 1'b0; din_valid = 1'b1; din = 9'b011_100_010;
        tick();
        din_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_ren", r_en, 8'd0);
        chk("mrst_gin", g_in, 1'b0);
        chk("mrst_alu", alu_op, 3'b100);
        chk("mrst_mux", mux_sel, 4'd0);
        chk("mrst_ret", retired, 16'd0);
        chk("mrst_ir", ir, 9'd0);
        chk("mrst_rdy", din_ready, 1'b1);
        tick();
        chk("mrst_ren2", r_en, 8'd0);
        rst = 1'b0;
        m_ret = 16'd0; m_ir = 9'd0;
        #1;
        chk("mrst_rdy_rel", din_ready, 1'b1);
        chk("mrst_done_rel", done, 1'b0);
        tick();

        // Wrap: back-to-back movi until the counter sits at FFFF.
        hold = 1'b0; din_valid = 1'b1; din = 9'b000_001_001;
        for (int n = 0; n < 2 * 65535; n++) @(posedge clk);
        #1;
        din_valid = 1'b0;
        m_ret = 16'hFFFF; m_ir = 9'b000_001_001;
        chk("wrap_pre", retired, 16'hFFFF);
        run_instr("wrap", 9'b000_010_000, 9, 0);
        chk("wrap_zero", retired, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
